cache_ctrl: RTL and testbench

- Controller for the 4-line, fully associative, write-back, write-allocate data cache. 7-bit tag is the full address; each line holds one data word.
- Owns the tag, data, valid and dirty arrays and the per-line LRU ages. Sequences lookup, dirty-victim writeback, fill and LRU update.
- Arbitrates between one CPU-side request port and one memory port. Drives the victim one-hot that selects writeback tag/data.

---
 rtl/cache_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Controller for a 4-line fully associative write-back / write-allocate cache.
// It owns the tag, data, valid, dirty and LRU-age arrays and sequences lookup, writeback, fill and update.
module cache_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        victim,
  output logic [2:0]        fsm_state
);

  // Handshake: a request is taken when req_valid && req_ready on a rising edge;
  // memory ops hold mem_rd/mem_wr until a cycle with mem_ready sampled high.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] tag_arr  [4];
  logic [DATA_W-1:0] data_arr [4];
  logic [1:0]        age      [4];
  logic [3:0]        vld;
  logic [3:0]        dirty;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              hit_q;

  logic [3:0] hit_vec;
  logic [3:0] sel_oh;
  logic [1:0] sel_idx;
  logic [1:0] vidx;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < 4; i++) hit_vec[i] = vld[i] && (tag_arr[i] == addr_q);
  end

  // Victim choice: hit way, else lowest invalid way, else the oldest way.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    if (|hit_vec) begin
      for (int i = 0; i < 4; i++) begin
        if (hit_vec[i]) begin
          sel_oh  = hit_vec;
          sel_idx = 2'(i);
        end
      end
    end else if (!(&vld)) begin
      for (int i = 3; i >= 0; i--) begin
        if (!vld[i]) begin
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
          sel_idx   = 2'(i);
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (age[i] == 2'd3) begin
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
          sel_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    vidx = '0;
    for (int i = 0; i < 4; i++) if (victim[i]) vidx = 2'(i);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req_valid) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (|hit_vec)                          state_nx = S_RESP;
        else if (vld[sel_idx] && dirty[sel_idx]) state_nx = S_WB;
        else if (write_q)                      state_nx = S_RESP;
        else                                   state_nx = S_FILL;
      end
      S_WB:     if (mem_ready) state_nx = write_q ? S_RESP : S_FILL;
      S_FILL:   if (mem_ready) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_hit   = (state == S_RESP) && hit_q;
    resp_rdata = (state == S_RESP) ? data_arr[vidx] : '0;
    mem_wr     = (state == S_WB);
    mem_rd     = (state == S_FILL);
    mem_wdata  = (state == S_WB) ? data_arr[vidx] : '0;
    mem_addr   = '0;
    if (state == S_WB)   mem_addr = tag_arr[vidx];
    if (state == S_FILL) mem_addr = addr_q;
    fsm_state  = state;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      victim  <= 4'b1000;
      vld     <= '0;
      dirty   <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_arr[i]  <= '0;
        data_arr[i] <= '0;
        age[i]      <= 2'(i);
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
          end
        end
        S_LOOKUP: begin
          victim <= sel_oh;
          hit_q  <= |hit_vec;
        end
        S_WB: if (mem_ready) dirty[vidx] <= 1'b0;
        S_FILL: begin
          if (mem_ready) begin
            data_arr[vidx] <= mem_rdata;
            tag_arr[vidx]  <= addr_q;
            vld[vidx]      <= 1'b1;
            dirty[vidx]    <= 1'b0;
          end
        end
        S_RESP: begin
          if (write_q) begin
            data_arr[vidx] <= wdata_q;
            tag_arr[vidx]  <= addr_q;
            vld[vidx]      <= 1'b1;
            dirty[vidx]    <= 1'b1;
          end
          // Ages younger than the accessed way shift up by one; accessed way becomes newest.
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == vidx)        age[i] <= 2'd0;
            else if (age[i] < age[vidx]) age[i] <= age[i] + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: a reference cache model feeds response and memory-op
// scoreboards, and a responsive memory model serves rd/wr with programmable latency.
module tb_cache_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_hit;
  logic       mem_rd;
  logic       mem_wr;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ready = 1'b0;
  logic [3:0] victim;
  logic [2:0] fsm_state;

  cache_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .victim(victim), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard and models ----------------
  // exp_q entry: {hit, is_load, rdata[7:0], victim[3:0], latency[7:0]}
  logic [21:0] exp_q[$];
  int          acc_q[$];
  // mem_q entry: {is_write, addr[6:0], wdata[7:0]}
  logic [15:0] mem_q[$];
  int          resp_cnt = 0;

  logic [7:0] mem_model [128];
  logic [6:0] m_tag  [4];
  logic [7:0] m_data [4];
  bit         m_vld  [4];
  bit         m_dirty[4];
  int         m_age  [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0; m_data[i] = '0; m_vld[i] = 0; m_dirty[i] = 0; m_age[i] = i;
    end
  endtask

  task automatic model_access(input bit w, input logic [6:0] a, input logic [7:0] d,
                              output bit hit, output logic [7:0] rd, output logic [3:0] vic,
                              output int nwb, output int nfill);
    int v = -1;
    int old;
    hit = 0; nwb = 0; nfill = 0;
    for (int i = 0; i < 4; i++) if (m_vld[i] && m_tag[i] == a) begin v = i; hit = 1; end
    if (!hit) for (int i = 0; i < 4; i++) if (!m_vld[i] && v < 0) v = i;
    if (v < 0) for (int i = 0; i < 4; i++) if (m_age[i] == 3) v = i;
    if (!hit && m_vld[v] && m_dirty[v]) begin
      mem_q.push_back({1'b1, m_tag[v], m_data[v]});
      m_dirty[v] = 0;
      nwb = 1;
    end
    if (!hit && !w) begin
      mem_q.push_back({1'b0, a, 8'h00});
      m_data[v] = mem_model[a]; m_tag[v] = a; m_vld[v] = 1; m_dirty[v] = 0;
      nfill = 1;
    end
    rd = m_data[v];
    if (w) begin
      m_data[v] = d; m_tag[v] = a; m_vld[v] = 1; m_dirty[v] = 1;
    end
    old = m_age[v];
    for (int i = 0; i < 4; i++) if (m_age[i] < old) m_age[i] = m_age[i] + 1;
    m_age[v] = 0;
    vic = 4'b0001 << v;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT completes a request.
  always @(negedge clock) begin
    if (resetn && resp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        logic [21:0] e;
        int t;
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("resp_hit", 32'(resp_hit), 32'(e[21]));
        if (e[20]) chk("resp_rdata", 32'(resp_rdata), 32'(e[19:12]));
        chk("resp_victim", 32'(victim), 32'(e[11:8]));
        chk("resp_latency", 32'(cyc - t), 32'(e[7:0]));
      end
      resp_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input bit w, input logic [6:0] a, input logic [7:0] d, output int t);
    int k = 0;
    while (!req_ready && k < 100) begin @(negedge clock); k++; end
    if (k >= 100) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    t = cyc;
    @(negedge clock);
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1);
    req_addr  = 7'($urandom_range(0, 127));
  endtask

  task automatic serve(input int lat, input int target);
    int wcnt = 0;
    logic [15:0] cur = '0;
    for (int k = 0; k < 400 && resp_cnt < target; k++) begin
      mem_ready = 1'b0;
      if (mem_rd || mem_wr) begin
        chk("mem_exclusive", 32'(mem_rd && mem_wr), 32'd0);
        if (wcnt == 0) begin
          if (mem_q.size() == 0) begin
            chk("mem_unexpected", 32'({mem_rd, mem_wr}), 32'd0);
            cur = {mem_wr, mem_addr, mem_wdata};
          end else begin
            cur = mem_q.pop_front();
            chk("mem_kind_wr", 32'(mem_wr), 32'(cur[15]));
            chk("mem_addr", 32'(mem_addr), 32'(cur[14:8]));
            if (cur[15]) chk("mem_wdata", 32'(mem_wdata), 32'(cur[7:0]));
          end
        end else begin
          chk("mem_hold_addr", 32'(mem_addr), 32'(cur[14:8]));
          if (cur[15]) chk("mem_hold_wdata", 32'(mem_wdata), 32'(cur[7:0]));
        end
        if (wcnt == lat) begin
          mem_ready = 1'b1;
          wcnt = 0;
          if (mem_wr) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
        end else begin
          wcnt++;
        end
      end
      @(negedge clock);
    end
    mem_ready = 1'b0;
    if (resp_cnt < target) chk("resp_timeout", 32'(resp_cnt), 32'(target));
  endtask

  task automatic do_req(input bit w, input logic [6:0] a, input logic [7:0] d, input int lat);
    bit hit;
    logic [7:0] rd;
    logic [3:0] vic;
    int nwb, nfill, t, target;
    model_access(w, a, d, hit, rd, vic, nwb, nfill);
    exp_q.push_back({hit, ~w, rd, vic, 8'(2 + (nwb + nfill) * (lat + 1))});
    target = resp_cnt + 1;
    start_req(w, a, d, t);
    acc_q.push_back(t);
    serve(lat, target);
    chk("mem_ops_drained", 32'(mem_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int k;
    for (int i = 0; i < 128; i++) mem_model[i] = 8'($urandom_range(0, 255));
    mem_model[7'h10] = 8'hA5;
    model_reset();

    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_mem_rd_wr", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_victim", 32'(victim), 32'h8);
    resetn = 1'b1;
    @(negedge clock);

    // Directed: cold fill, hit, fill remaining ways, LRU eviction of clean way0.
    do_req(0, 7'h10, 8'h00, 1);
    do_req(0, 7'h10, 8'h00, 0);
    do_req(0, 7'h11, 8'h00, 0);
    do_req(0, 7'h12, 8'h00, 0);
    do_req(0, 7'h13, 8'h00, 0);
    do_req(0, 7'h14, 8'h00, 1);
    // Dirty line 0x11 eventually evicted; writeback held three cycles.
    do_req(1, 7'h11, 8'h3C, 0);
    do_req(0, 7'h20, 8'h00, 0);
    do_req(0, 7'h21, 8'h00, 0);
    do_req(0, 7'h22, 8'h00, 0);
    do_req(0, 7'h23, 8'h00, 2);
    // Store miss into an all-clean cache needs no memory traffic.
    do_req(1, 7'h30, 8'h77, 0);
    do_req(0, 7'h30, 8'h00, 0);

    // Random mix over a small address window to force hits, misses and dirty evictions.
    repeat (40) do_req($urandom_range(0, 1), 7'($urandom_range(0, 7)),
                       8'($urandom_range(0, 255)), $urandom_range(0, 3));

    // Make every line dirty, then abort a writeback with reset.
    do_req(1, 7'h50, 8'h01, 0);
    do_req(1, 7'h51, 8'h02, 0);
    do_req(1, 7'h52, 8'h03, 0);
    do_req(1, 7'h53, 8'h04, 0);
    start_req(0, 7'h60, 8'h00, t);
    k = 0;
    while (!mem_wr && k < 20) begin @(negedge clock); k++; end
    chk("abort_wb_active", 32'(mem_wr), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_victim", 32'(victim), 32'h8);
    chk("abort_state", 32'(fsm_state), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    mem_q.delete();
    @(negedge clock);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    do_req(0, 7'h11, 8'h00, 1);

    repeat (2) @(negedge clock);
    chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
